// File: rtl/ddr2_rd_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_rd_arb_pkg
// Shared definitions for the ddr2_mgr read-port arbiter: field widths, the
// arbiter state encoding, the latched command payload and a helper that turns
// a transfer length into the number of returned 32-bit words.
// ----------------------------------------------------------------------------
package ddr2_rd_arb_pkg;

  localparam int unsigned ARB_ADDR_W  = 25;
  localparam int unsigned ARB_LEN_W   = 10;
  localparam int unsigned ARB_CNT_W   = 11;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_OWN_W   = 2;
  localparam int unsigned ARB_MAX_REQ = 4;

  typedef enum logic [1:0] {
    ST_ARB_IDLE = 2'd0,
    ST_ARB_REQ  = 2'd1,
    ST_ARB_XFR  = 2'd2,
    ST_ARB_DONE = 2'd3
  } arb_state_t;

  // Command captured from the winning requester at arbitration time.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LEN_W-1:0]  len;
  } arb_cmd_t;

  // Words returned by ddr2_mgr for a transfer of len units.
  function automatic logic [ARB_CNT_W-1:0] arb_xfr_words(input logic [ARB_LEN_W-1:0] len,
                                                         input int unsigned           wpx);
    return ARB_CNT_W'(32'(len) * wpx);
  endfunction

endpackage

// File: rtl/ddr2_rd_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// ddr2_rd_arb_rr_pick
// Combinational rotate-priority picker. Searches the request vector starting
// one position after the pointer and wrapping, returning the first hit.
// Ports:
//   i_req     request vector
//   i_ptr     index of the last winner
//   o_onehot  one-hot winner
//   o_idx     winner index
//   o_any     at least one request present
// ----------------------------------------------------------------------------
module ddr2_rd_arb_rr_pick
  import ddr2_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [ARB_OWN_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_onehot,
  output logic [ARB_OWN_W-1:0] o_idx,
  output logic                 o_any
);

  int unsigned        w_pos;
  logic [NUM_REQ-1:0] w_mask;

  // Scan from the farthest slot to the nearest so the nearest hit overrides.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    w_mask   = '0;
    for (int unsigned k = NUM_REQ; k != 0; k--) begin
      w_pos  = (32'(i_ptr) + k) % NUM_REQ;
      w_mask = NUM_REQ'(1) << w_pos;
      if ((i_req & w_mask) != '0) begin
        o_onehot = w_mask;
        o_idx    = ARB_OWN_W'(w_pos);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_rd_arb.sv
// ----------------------------------------------------------------------------
// ddr2_rd_arb
// Shares the single ddr2_mgr read port among NUM_REQ requesters. Round-robin
// arbitration, one transfer in flight, grant/valid/done steered to the owner,
// returned-word counting and a sticky protocol-error flag.
// Optional build macro DDR2_ARB_PRIO0_EN: requester 0 gets strict priority,
// round-robin applies among the remaining requesters only.
// Ports:
//   clk0, rst0               clock, synchronous active-high reset
//   req/req_addr/req_len     per-requester request, start address, length
//   req_grant                one-cycle accept pulse to the owner
//   req_data/req_data_valid  returned data (broadcast) / owner-steered valid
//   req_done                 one-cycle completion pulse to the owner
//   mem_rd_*                 ddr2_mgr read port
//   busy, owner, err_proto   status
// ----------------------------------------------------------------------------
module ddr2_rd_arb
  import ddr2_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned WORDS_PER_XFR = 2
) (
  input  logic                            clk0,
  input  logic                            rst0,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ARB_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*ARB_LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [ARB_DATA_W-1:0]           req_data,
  output logic [NUM_REQ-1:0]              req_data_valid,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            mem_rd_req,
  output logic [ARB_ADDR_W-1:0]           mem_rd_addr,
  output logic [ARB_LEN_W-1:0]            mem_rd_xfr_len,
  input  logic                            mem_rd_grant,
  input  logic [ARB_DATA_W-1:0]           mem_rd_data,
  input  logic                            mem_rd_data_valid,
  output logic                            busy,
  output logic [ARB_OWN_W-1:0]            owner,
  output logic                            err_proto
);

  arb_state_t           r_state;
  arb_cmd_t             r_cmd;
  logic [ARB_OWN_W-1:0] r_owner;
  logic [ARB_OWN_W-1:0] r_rr_ptr;
  logic [ARB_CNT_W-1:0] r_expected;
  logic [ARB_CNT_W-1:0] r_count;
  logic                 r_mem_req;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;

  logic [ARB_ADDR_W-1:0] w_addr_arr [ARB_MAX_REQ];
  logic [ARB_LEN_W-1:0]  w_len_arr  [ARB_MAX_REQ];
  logic [NUM_REQ-1:0]    w_pick_req;
  logic [NUM_REQ-1:0]    w_pick_oh;
  logic [ARB_OWN_W-1:0]  w_pick_idx;
  logic                  w_pick_any;
  logic [NUM_REQ-1:0]    w_win_oh;
  logic [ARB_OWN_W-1:0]  w_win_idx;
  logic                  w_win_any;
  logic                  w_ptr_upd;
  logic [NUM_REQ-1:0]    w_own_mask;
  logic [ARB_LEN_W-1:0]  w_win_len;
  logic [ARB_CNT_W-1:0]  w_count_nxt;

  // Unpack the flat per-requester buses; unused slots read as zero so the
  // 2-bit owner index can select directly.
  for (genvar g = 0; g < ARB_MAX_REQ; g++) begin : g_slot
    if (g < NUM_REQ) begin : g_used
      assign w_addr_arr[g] = req_addr[g*ARB_ADDR_W +: ARB_ADDR_W];
      assign w_len_arr[g]  = req_len[g*ARB_LEN_W +: ARB_LEN_W];
    end else begin : g_unused
      assign w_addr_arr[g] = '0;
      assign w_len_arr[g]  = '0;
    end
  end

  ddr2_rd_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (w_pick_req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

`ifdef DDR2_ARB_PRIO0_EN
  // Requester 0 wins outright and leaves the rotation untouched.
  assign w_pick_req = req & ~NUM_REQ'(1);

  always_comb begin
    w_win_oh  = w_pick_oh;
    w_win_idx = w_pick_idx;
    w_win_any = w_pick_any;
    w_ptr_upd = 1'b1;
    if (req[0]) begin
      w_win_oh  = NUM_REQ'(1);
      w_win_idx = '0;
      w_win_any = 1'b1;
      w_ptr_upd = 1'b0;
    end
  end
`else
  assign w_pick_req = req;
  assign w_win_oh   = w_pick_oh;
  assign w_win_idx  = w_pick_idx;
  assign w_win_any  = w_pick_any;
  assign w_ptr_upd  = 1'b1;
`endif

  assign w_win_len   = w_len_arr[w_win_idx];
  assign w_own_mask  = NUM_REQ'(1) << r_owner;
  assign w_count_nxt = r_count + ARB_CNT_W'(1);

  // Arbitration FSM, command latches, word counter and error flag.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state    <= ST_ARB_IDLE;
      r_cmd      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= ARB_OWN_W'(NUM_REQ - 1);
      r_expected <= '0;
      r_count    <= '0;
      r_mem_req  <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_done <= '0;

      if ((mem_rd_data_valid && (r_state != ST_ARB_XFR)) ||
          (mem_rd_grant      && (r_state != ST_ARB_REQ))) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_ARB_IDLE: begin
          if (w_win_any) begin
            r_owner    <= w_win_idx;
            r_cmd.addr <= w_addr_arr[w_win_idx];
            r_cmd.len  <= w_win_len;
            if (w_ptr_upd) begin
              r_rr_ptr <= w_win_idx;
            end
            // Zero-length requests complete without touching ddr2_mgr.
            if (w_win_len == '0) begin
              r_state <= ST_ARB_DONE;
              r_done  <= w_win_oh;
            end else begin
              r_state   <= ST_ARB_REQ;
              r_mem_req <= 1'b1;
            end
          end
        end

        ST_ARB_REQ: begin
          if (mem_rd_grant) begin
            r_mem_req  <= 1'b0;
            r_expected <= arb_xfr_words(r_cmd.len, WORDS_PER_XFR);
            r_count    <= '0;
            r_state    <= ST_ARB_XFR;
          end
        end

        ST_ARB_XFR: begin
          if (mem_rd_data_valid) begin
            r_count <= w_count_nxt;
            if (w_count_nxt == r_expected) begin
              r_state <= ST_ARB_DONE;
              r_done  <= w_own_mask;
            end
          end
        end

        ST_ARB_DONE: begin
          r_state <= ST_ARB_IDLE;
        end

        default: begin
          r_state <= ST_ARB_IDLE;
        end
      endcase
    end
  end

  // Grant and data-valid are steered combinationally to the current owner.
  assign req_grant      = ((r_state == ST_ARB_REQ) && mem_rd_grant)      ? w_own_mask : '0;
  assign req_data_valid = ((r_state == ST_ARB_XFR) && mem_rd_data_valid) ? w_own_mask : '0;
  assign req_data       = mem_rd_data;
  assign req_done       = r_done;
  assign mem_rd_req     = r_mem_req;
  assign mem_rd_addr    = r_cmd.addr;
  assign mem_rd_xfr_len = r_cmd.len;
  assign busy           = (r_state != ST_ARB_IDLE);
  assign owner          = r_owner;
  assign err_proto      = r_err;

endmodule

// File: tb/tb_ddr2_rd_arb.sv
// ----------------------------------------------------------------------------
// tb_ddr2_rd_arb
// Directed bench for ddr2_rd_arb (NUM_REQ=2, WORDS_PER_XFR=2). Inputs change
// on the falling edge; outputs are sampled on the falling edge or 1ns after
// an input change for the combinational steering paths.
// ----------------------------------------------------------------------------
module tb_ddr2_rd_arb;

  logic        clk0;
  logic        rst0;
  logic [1:0]  req;
  logic [49:0] req_addr;
  logic [19:0] req_len;
  logic [1:0]  req_grant;
  logic [31:0] req_data;
  logic [1:0]  req_data_valid;
  logic [1:0]  req_done;
  logic        mem_rd_req;
  logic [24:0] mem_rd_addr;
  logic [9:0]  mem_rd_xfr_len;
  logic        mem_rd_grant;
  logic [31:0] mem_rd_data;
  logic        mem_rd_data_valid;
  logic        busy;
  logic [1:0]  owner;
  logic        err_proto;

  int n_total = 0;
  int n_bad   = 0;

  ddr2_rd_arb #(
    .NUM_REQ       (2),
    .WORDS_PER_XFR (2)
  ) dut (
    .clk0              (clk0),
    .rst0              (rst0),
    .req               (req),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .req_grant         (req_grant),
    .req_data          (req_data),
    .req_data_valid    (req_data_valid),
    .req_done          (req_done),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_xfr_len    (mem_rd_xfr_len),
    .mem_rd_grant      (mem_rd_grant),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_valid (mem_rd_data_valid),
    .busy              (busy),
    .owner             (owner),
    .err_proto         (err_proto)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst0              = 1'b1;
    req               = 2'b00;
    mem_rd_grant      = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_rd_data       = 32'h0;
    repeat (2) @(negedge clk0);
    rst0 = 1'b0;
  endtask

  // Waits for mem_rd_req, grants it, returns n_send words, then optionally
  // checks the done pulse and the idle cycle that follows.
  task automatic do_xfr(input string tag, input int who, input logic [24:0] e_addr,
                        input logic [9:0] e_len, input int n_send, input bit exp_done);
    bit          seen;
    logic [31:0] d;
    logic [1:0]  mask;
    mask = 2'(1 << who);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_rd_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk0);
    end
    chk({tag, "_req_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, "_owner"}, 32'(owner), 32'(who));
    chk({tag, "_addr"}, 32'(mem_rd_addr), 32'(e_addr));
    chk({tag, "_len"}, 32'(mem_rd_xfr_len), 32'(e_len));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    mem_rd_grant = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(req_grant), 32'(mask));
    @(negedge clk0);
    mem_rd_grant = 1'b0;
    #1;
    chk({tag, "_req_drop"}, 32'(mem_rd_req), 32'd0);
    for (int w = 0; w < n_send; w++) begin
      d                 = $urandom;
      mem_rd_data       = d;
      mem_rd_data_valid = 1'b1;
      #1;
      chk({tag, "_dv"}, 32'(req_data_valid), 32'(mask));
      chk({tag, "_data"}, req_data, d);
      chk({tag, "_early_done"}, 32'(req_done), 32'd0);
      @(negedge clk0);
    end
    mem_rd_data_valid = 1'b0;
    #1;
    if (exp_done) begin
      chk({tag, "_done"}, 32'(req_done), 32'(mask));
      @(negedge clk0);
      chk({tag, "_done_clr"}, 32'(req_done), 32'd0);
      chk({tag, "_idle_gap"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_own;
    req_addr = '0;
    req_len  = '0;
    do_reset();

    // Reset state.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_rd_req), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(err_proto), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);

    // Single transfer: len 4 -> 8 words.
    req_addr[24:0] = 25'h0001000;
    req_len[9:0]   = 10'h004;
    req            = 2'b01;
    #1;
    chk("t1_req_lat0", 32'(mem_rd_req), 32'd0);
    @(negedge clk0);
    chk("t1_req_lat1", 32'(mem_rd_req), 32'd1);
    do_xfr("t1", 0, 25'h0001000, 10'h004, 8, 1'b1);
    req = 2'b00;
    chk("t1_err", 32'(err_proto), 32'd0);

    // Both requesting continuously, len 1 each.
    do_reset();
    req_addr[24:0]  = 25'h0002000;
    req_addr[49:25] = 25'h0003000;
    req_len[9:0]    = 10'd1;
    req_len[19:10]  = 10'd1;
    req             = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef DDR2_ARB_PRIO0_EN
      e_own = 0;
`else
      e_own = k % 2;
`endif
      do_xfr("t2", e_own, (e_own == 0) ? 25'h0002000 : 25'h0003000, 10'd1, 2, 1'b1);
    end
    req = 2'b00;

    // Zero-length request from requester 1.
    do_reset();
    req_len[19:10] = 10'd0;
    req            = 2'b10;
    #1;
    chk("t3_busy_pre", 32'(busy), 32'd0);
    @(negedge clk0);
    req = 2'b00;
    chk("t3_done", 32'(req_done), 32'b10);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_owner", 32'(owner), 32'd1);
    chk("t3_mem_req", 32'(mem_rd_req), 32'd0);
    @(negedge clk0);
    chk("t3_done_clr", 32'(req_done), 32'd0);
    chk("t3_busy_clr", 32'(busy), 32'd0);
    chk("t3_mem_req2", 32'(mem_rd_req), 32'd0);

    // Spurious data-valid and grant in IDLE.
    do_reset();
    mem_rd_data       = 32'hDEADBEEF;
    mem_rd_data_valid = 1'b1;
    #1;
    chk("t4_dv_blocked", 32'(req_data_valid), 32'd0);
    chk("t4_data_pass", req_data, 32'hDEADBEEF);
    @(negedge clk0);
    mem_rd_data_valid = 1'b0;
    chk("t4_err_set", 32'(err_proto), 32'd1);
    repeat (3) @(negedge clk0);
    chk("t4_err_sticky", 32'(err_proto), 32'd1);
    rst0 = 1'b1;
    @(negedge clk0);
    rst0 = 1'b0;
    chk("t4_err_rst", 32'(err_proto), 32'd0);
    mem_rd_grant = 1'b1;
    #1;
    chk("t4_grant_blocked", 32'(req_grant), 32'd0);
    @(negedge clk0);
    mem_rd_grant = 1'b0;
    chk("t4_grant_err", 32'(err_proto), 32'd1);

    // Reset after 3 of 8 words, then a fresh transfer.
    do_reset();
    req_len[9:0] = 10'h004;
    req          = 2'b01;
    do_xfr("t5a", 0, 25'h0002000, 10'h004, 3, 1'b0);
    rst0 = 1'b1;
    @(negedge clk0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_req", 32'(mem_rd_req), 32'd0);
    chk("t5_done", 32'(req_done), 32'd0);
    chk("t5_addr", 32'(mem_rd_addr), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    rst0 = 1'b0;
    do_xfr("t5b", 0, 25'h0002000, 10'h004, 8, 1'b1);
    req = 2'b00;
    chk("t5_err", 32'(err_proto), 32'd0);

    // Requester 0 drops req while waiting for the grant.
    do_reset();
    req = 2'b01;
    @(negedge clk0);
    req = 2'b00;
    repeat (2) begin
      @(negedge clk0);
      chk("t6_req_hold", 32'(mem_rd_req), 32'd1);
    end
    do_xfr("t6", 0, 25'h0002000, 10'h004, 8, 1'b1);
    chk("t6_err", 32'(err_proto), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
